// File: rtl/rx_ctrl.sv
// rx_ctrl -- receive-side controller for an idle-high asynchronous serial link
// (1 start bit, DATA_BITS data bits LSB-first, 1 stop bit).
//
// The controller qualifies the start bit and times each bit period. It pulses
// sr_shift_enable once per data bit, at the bit's sample point, for an external
// shift register that sees the same serial line. It then checks the stop bit,
// captures the assembled word into rx_data, and holds it for the consumer
// with a ready/acknowledge handshake.
//
// Ports
//   clk              in   system clock, rising edge
//   rst              in   synchronous active-high reset
//   serial_in        in   serial line (already synchronised), idle high
//   sr_data          in   parallel output of the external shift register
//   read_enable      in   consumer acknowledge of rx_data
//   sr_shift_enable  out  one-cycle shift strobe, mid data bit
//   rx_data          out  last correctly framed word
//   data_ready       out  rx_data holds an unread word
//   framing_error    out  last frame had a low stop bit (sticky until next start)
//   overrun_error    out  an unread word was overwritten
//   busy             out  frame in progress
module rx_ctrl #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 10,
    parameter int SAMPLE_POINT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 serial_in,
    input  logic [DATA_BITS-1:0] sr_data,
    input  logic                 read_enable,
    output logic                 sr_shift_enable,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 data_ready,
    output logic                 framing_error,
    output logic                 overrun_error,
    output logic                 busy
);

    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int CW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [TW-1:0] T_SAMPLE = TW'(SAMPLE_POINT);
    localparam logic [TW-1:0] T_LAST   = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] T_ONE    = TW'(1);
    localparam logic [CW-1:0] C_LAST   = CW'(DATA_BITS - 1);
    localparam logic [CW-1:0] C_ONE    = CW'(1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        LOAD
    } state_t;

    state_t          state;
    logic [TW-1:0]   bit_timer;
    logic [CW-1:0]   bit_cnt;
    logic            stop_ok;

    // The strobe is decoded from registered state so the shift register
    // samples the line on the edge that ends the sample-point cycle.
    assign sr_shift_enable = (state == DATA) && (bit_timer == T_SAMPLE);
    assign busy            = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            bit_timer     <= '0;
            bit_cnt       <= '0;
            stop_ok       <= 1'b0;
            rx_data       <= '0;
            data_ready    <= 1'b0;
            framing_error <= 1'b0;
            overrun_error <= 1'b0;
        end else begin
            // Consumer handshake; a good LOAD below overrides it in the same cycle.
            if (read_enable && data_ready) begin
                data_ready    <= 1'b0;
                overrun_error <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (!serial_in) begin
                        state         <= START;
                        bit_timer     <= '0;
                        framing_error <= 1'b0;
                    end
                end

                START: begin
                    // A line back high at the sample point was a glitch.
                    if ((bit_timer == T_SAMPLE) && serial_in) begin
                        state     <= IDLE;
                        bit_timer <= '0;
                    end else if (bit_timer == T_LAST) begin
                        state     <= DATA;
                        bit_timer <= '0;
                        bit_cnt   <= '0;
                    end else begin
                        bit_timer <= bit_timer + T_ONE;
                    end
                end

                DATA: begin
                    if (bit_timer == T_LAST) begin
                        bit_timer <= '0;
                        if (bit_cnt == C_LAST) begin
                            state <= STOP;
                        end else begin
                            bit_cnt <= bit_cnt + C_ONE;
                        end
                    end else begin
                        bit_timer <= bit_timer + T_ONE;
                    end
                end

                STOP: begin
                    // Leave mid stop bit so a following start bit is not missed.
                    if (bit_timer == T_SAMPLE) begin
                        stop_ok   <= serial_in;
                        state     <= LOAD;
                        bit_timer <= '0;
                    end else begin
                        bit_timer <= bit_timer + T_ONE;
                    end
                end

                LOAD: begin
                    state <= IDLE;
                    if (stop_ok) begin
                        rx_data    <= sr_data;
                        data_ready <= 1'b1;
                        if (data_ready && !read_enable) begin
                            overrun_error <= 1'b1;
                        end
                    end else begin
                        framing_error <= 1'b1;
                    end
                end

                default: begin
                    state     <= IDLE;
                    bit_timer <= '0;
                    bit_cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rx_ctrl.sv
// tb_rx_ctrl -- self-checking bench for rx_ctrl with default parameters.
// The external shift register is modelled behaviourally; expected outputs come
// from a frame-level model: each frame starting at edge E0 yields strobes at
// E0+14+10*i, and its result (word / framing error / overrun) lands at E0+96.
module tb_rx_ctrl;

    localparam int DB   = 8;
    localparam int CPB  = 10;
    localparam int SP   = 4;
    localparam int LAT  = (1 + DB) * CPB + SP + 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          serial_in;
    logic [DB-1:0] sr_data;
    logic          read_enable;
    logic          sr_shift_enable;
    logic [DB-1:0] rx_data;
    logic          data_ready;
    logic          framing_error;
    logic          overrun_error;
    logic          busy;

    rx_ctrl #(.DATA_BITS(DB), .CLKS_PER_BIT(CPB), .SAMPLE_POINT(SP)) dut (
        .clk             (clk),
        .rst             (rst),
        .serial_in       (serial_in),
        .sr_data         (sr_data),
        .read_enable     (read_enable),
        .sr_shift_enable (sr_shift_enable),
        .rx_data         (rx_data),
        .data_ready      (data_ready),
        .framing_error   (framing_error),
        .overrun_error   (overrun_error),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Shift register: new bit enters at the MSB, so LSB-first data lands in order.
    logic [DB-1:0] sr = '0;
    always @(posedge clk) if (sr_shift_enable) sr <= {serial_in, sr[DB-1:1]};
    assign sr_data = sr;

    int strobes[$];
    always @(posedge clk) begin
        #1;
        if (sr_shift_enable === 1'b1) strobes.push_back(cyc);
    end

    int checks = 0;
    int errors = 0;

    // Reference model of the consumer-visible registers.
    logic [DB-1:0] m_data;
    logic          m_ready, m_ferr, m_ovr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic wait_edge(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_regs(input string tag);
        check({tag, "_rx_data"}, 32'(rx_data), 32'(m_data));
        check({tag, "_ready"}, 32'(data_ready), 32'(m_ready));
        check({tag, "_ferr"}, 32'(framing_error), 32'(m_ferr));
        check({tag, "_ovr"}, 32'(overrun_error), 32'(m_ovr));
    endtask

    task automatic check_strobes(input int e0, input int n);
        check("strobe_count", 32'(strobes.size()), 32'(n));
        for (int i = 0; i < n && i < strobes.size(); i++)
            check("strobe_time", 32'(strobes[i]), 32'(e0 + CPB + SP + CPB * i));
    endtask

    task automatic send_frame(input logic [DB-1:0] d, input logic stop, input logic rd_at_load);
        int e0;
        logic [DB+1:0] bits;
        bits = {stop, d, 1'b0};
        @(negedge clk);
        strobes.delete();
        e0 = cyc + 1;
        fork
            begin
                for (int b = 0; b < DB + 2; b++) begin
                    serial_in = bits[b];
                    // Stop bit is cut short so a low stop bit is not seen as a new start.
                    repeat ((b == DB + 1) ? SP + 2 : CPB) @(negedge clk);
                end
                serial_in = 1'b1;
            end
            begin
                wait_edge(e0);
                m_ferr = 1'b0;
                check("start_busy", 32'(busy), 32'd1);
                check("start_ferr", 32'(framing_error), 32'd0);
                wait_edge(e0 + LAT - 1);
                check("preload_ready", 32'(data_ready), 32'(m_ready));
                check("preload_busy", 32'(busy), 32'd1);
                @(negedge clk);
                read_enable = rd_at_load;
                wait_edge(e0 + LAT);
                read_enable = 1'b0;
                if (stop) begin
                    m_ovr   = (m_ready && !rd_at_load) ? 1'b1 : (rd_at_load ? 1'b0 : m_ovr);
                    m_data  = d;
                    m_ready = 1'b1;
                end else begin
                    m_ferr = 1'b1;
                    if (rd_at_load && m_ready) begin
                        m_ready = 1'b0;
                        m_ovr   = 1'b0;
                    end
                end
                check("load_busy", 32'(busy), 32'd0);
                check_regs("load");
            end
        join
        wait_edge(e0 + LAT + 4);
        check_strobes(e0, stop ? DB : DB);
    endtask

    task automatic do_read();
        @(negedge clk);
        read_enable = 1'b1;
        @(posedge clk);
        #1;
        read_enable = 1'b0;
        if (m_ready) begin
            m_ready = 1'b0;
            m_ovr   = 1'b0;
        end
        check_regs("read");
    endtask

    task automatic false_start();
        int e0;
        @(negedge clk);
        strobes.delete();
        e0 = cyc + 1;
        serial_in = 1'b0;
        repeat (3) @(negedge clk);
        serial_in = 1'b1;
        wait_edge(e0 + SP);
        check("fs_busy_before", 32'(busy), 32'd1);
        wait_edge(e0 + SP + 1);
        check("fs_busy_after", 32'(busy), 32'd0);
        wait_edge(e0 + 3 * CPB);
        check("fs_strobes", 32'(strobes.size()), 32'd0);
        check_regs("fs");
    endtask

    task automatic reset_mid_frame(input logic [DB-1:0] d);
        int e0;
        @(negedge clk);
        strobes.delete();
        e0 = cyc + 1;
        serial_in = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int b = 0; b < 3; b++) begin
            serial_in = d[b];
            repeat ((b == 2) ? SP + 1 : CPB) @(negedge clk);
        end
        // Now just before edge E0+35, after the third strobe.
        rst = 1'b1;
        serial_in = 1'b1;
        wait_edge(e0 + 3 * CPB + SP + 1);
        m_data = '0; m_ready = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check_regs("rst_mid");
        @(negedge clk);
        rst = 1'b0;
        wait_edge(e0 + 8 * CPB);
        check("rst_strobes", 32'(strobes.size()), 32'd3);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DB-1:0] rd;
        rst = 1'b1;
        serial_in = 1'b1;
        read_enable = 1'b0;
        m_data = '0; m_ready = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_strobe", 32'(sr_shift_enable), 32'd0);
        check_regs("reset");
        @(negedge clk);
        rst = 1'b0;
        strobes.delete();
        repeat (50) @(posedge clk);
        #1;
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_strobes", 32'(strobes.size()), 32'd0);

        send_frame(8'hA5, 1'b1, 1'b0);
        false_start();
        do_read();
        send_frame(8'h3C, 1'b0, 1'b0);
        send_frame(8'h11, 1'b1, 1'b0);
        do_read();
        send_frame(8'h12, 1'b1, 1'b0);
        send_frame(8'h34, 1'b1, 1'b0);
        do_read();
        send_frame(8'h66, 1'b1, 1'b0);
        send_frame(8'h77, 1'b1, 1'b1);
        do_read();
        reset_mid_frame(8'hC3);
        send_frame(8'h5A, 1'b1, 1'b0);

        for (int i = 0; i < 10; i++) begin
            rd = 8'($urandom);
            send_frame(rd, ($urandom % 4) != 0, ($urandom % 4) == 0);
            if ($urandom % 2) do_read();
            repeat ($urandom_range(0, 15)) @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
